max_filter_ctrl: RTL

- Sequencer that runs the 5-input maximum comparator across a whole image.
- For each pixel, it fetches a plus-shaped neighbourhood from the source image RAM: centre, up, down, left, right.
- It presents those five pixels to the external comparator (inputs A..E, output mayor) and writes the maximum to the destination RAM.
- It sits between the frame buffers and the comparator and is started by the top-level filter control.

---
 rtl/max_filter_ctrl_pkg.sv | 21 ++
 rtl/max_filter_ctrl_if.sv | 34 +++
 rtl/max_filter_ctrl_addr_gen.sv | 36 +++
 rtl/max_filter_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/max_filter_ctrl_pkg.sv
// Shared definitions for the max-filter sequencer: FSM state encoding,
// neighbour indices and the default pixel width.
package filter_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] NB_C = 3'd0;
  localparam logic [2:0] NB_U = 3'd1;
  localparam logic [2:0] NB_D = 3'd2;
  localparam logic [2:0] NB_L = 3'd3;
  localparam logic [2:0] NB_R = 3'd4;

endpackage

// File: rtl/max_filter_ctrl_if.sv
// Control, frame-buffer and comparator signals of the max-filter sequencer.
// master = sequencer side, slave = frame buffers / comparator / top control.
interface max_filter_ctrl_if
  import filter_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  cmp_a, cmp_b, cmp_c, cmp_d, cmp_e;
  logic [PIX_W-1:0]  cmp_mayor;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  start, rd_data, cmp_mayor,
    output busy, done, rd_en, rd_addr,
           cmp_a, cmp_b, cmp_c, cmp_d, cmp_e,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, cmp_mayor,
    input  busy, done, rd_en, rd_addr,
           cmp_a, cmp_b, cmp_c, cmp_d, cmp_e,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/max_filter_ctrl_addr_gen.sv
// Combinational neighbour address generator. Out-of-image neighbours fall
// back to the centre address so the border pixel is replicated.
module max_filter_addr_gen
  import filter_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int XW     = 6,
  parameter int YW     = 6
) (
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [2:0]        k_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] centre_o
);
  localparam logic [ADDR_W-1:0] ROW_A = ADDR_W'(IMG_W);

  logic [ADDR_W-1:0] centre_s;

  assign centre_s = ADDR_W'(y_i) * ROW_A + ADDR_W'(x_i);
  assign centre_o = centre_s;

  // Validity is decided on x/y first, so the subtractions below never underflow.
  always_comb begin
    addr_o = centre_s;
    case (k_i)
      NB_U:    addr_o = (y_i != YW'(0))         ? centre_s - ROW_A          : centre_s;
      NB_D:    addr_o = (y_i != YW'(IMG_H - 1)) ? centre_s + ROW_A          : centre_s;
      NB_L:    addr_o = (x_i != XW'(0))         ? centre_s - ADDR_W'(1)     : centre_s;
      NB_R:    addr_o = (x_i != XW'(IMG_W - 1)) ? centre_s + ADDR_W'(1)     : centre_s;
      default: addr_o = centre_s;
    endcase
  end
endmodule

// File: rtl/max_filter_ctrl.sv
// Frame sequencer: per pixel, fetch the plus-shaped neighbourhood (5 cycles),
// capture the last read (1 cycle), write the comparator maximum (1 cycle).
module max_filter_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  max_filter_ctrl_if.master    bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [2:0]        k_q, k_d;
  logic [PIX_W-1:0]  op_q [5];
  logic [PIX_W-1:0]  op_d [5];
  logic [ADDR_W-1:0] nb_addr_s, centre_s;
  logic              rd_en_s, wr_en_s, busy_s, done_s;

  max_filter_addr_gen #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W), .XW (XW), .YW (YW)
  ) u_addr_gen (
    .x_i      (x_q),
    .y_i      (y_q),
    .k_i      (k_q),
    .addr_o   (nb_addr_s),
    .centre_o (centre_s)
  );

  // Next-state and Moore outputs; read data lags its address by one cycle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    op_d    = op_q;
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        rd_en_s = 1'b1;
        case (k_q)
          NB_U:    op_d[NB_C] = bus.rd_data;
          NB_D:    op_d[NB_U] = bus.rd_data;
          NB_L:    op_d[NB_D] = bus.rd_data;
          NB_R:    op_d[NB_L] = bus.rd_data;
          default: op_d = op_q;
        endcase
        if (k_q == NB_R) begin
          state_d = ST_CAPT;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_CAPT: begin
        op_d[NB_R] = bus.rd_data;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_s = 1'b1;
        if (x_q == XW'(IMG_W - 1) && y_q == YW'(IMG_H - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = '0;
          state_d = ST_FETCH;
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < 5; i++) op_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy    = busy_s;
  assign bus.done    = done_s;
  assign bus.rd_en   = rd_en_s;
  assign bus.rd_addr = nb_addr_s;
  assign bus.wr_en   = wr_en_s;
  assign bus.wr_addr = centre_s;
  assign bus.wr_data = bus.cmp_mayor;
  assign bus.cmp_a   = op_q[NB_C];
  assign bus.cmp_b   = op_q[NB_U];
  assign bus.cmp_c   = op_q[NB_D];
  assign bus.cmp_d   = op_q[NB_L];
  assign bus.cmp_e   = op_q[NB_R];
endmodule
